// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e            FSM state encoding, also exported on debug_state
//   DEFAULT_CLOCKS_PER_BIT bit period for 50 MHz / 115200 baud (50e6/115200 + 1)
//   TIMEOUT_MULT           watchdog limit in bit periods; a two-byte frame
//                          needs about 10 bit times per byte, so 12 leaves margin
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_HDR = 3'd1,
    WAIT_HDR = 3'd2,
    LOAD_PAY = 3'd3,
    WAIT_PAY = 3'd4,
    COMPLETE = 3'd5
  } arb_state_e;

  localparam int DEFAULT_CLOCKS_PER_BIT = 435;
  localparam int TIMEOUT_MULT           = 12;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin winner selection.
//   request      in  per-requester request levels
//   last_served  in  index of the requester served most recently
//   winner_idx   out first requesting index found searching from
//                    last_served+1, wrapping modulo NUM_REQUESTERS
//   any_request  out at least one request bit is high
// When no request is pending, winner_idx holds last_served (don't-care).
module round_robin_picker #(
  parameter int NUM_REQUESTERS = 4,
  parameter int IDX_W          = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic [IDX_W-1:0]          last_served,
  output logic [IDX_W-1:0]          winner_idx,
  output logic                      any_request
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    winner_idx  = last_served;
    any_request = |request;
    found       = 1'b0;
    cand        = '0;
    // Offsets 1..N visit every index once; offset N is last_served itself,
    // so a lone requester that was just served still wins.
    for (int i = 1; i <= NUM_REQUESTERS; i++) begin
      cand = IDX_W'((int'(last_served) + i) % NUM_REQUESTERS);
      if (!found && request[cand]) begin
        winner_idx = cand;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among several
// requesters. Each requester submits a header byte and a payload byte; the
// granted frame is latched and sent byte by byte through has_data /
// data_to_send, advancing on transmission_done.
//
// Optional watchdog: define UART_TX_ARB_TIMEOUT_EN to abort a frame whose
// byte is not acknowledged within TIMEOUT_MULT*CLOCKS_PER_BIT cycles.
//
// Ports:
//   clock, reset_n     rising-edge clock, synchronous active-low reset
//   request            per-requester level request
//   request_header     header byte of requester i in bits [8i+7:8i]
//   request_payload    payload byte of requester i in bits [8i+7:8i]
//   grant              one-hot single-cycle pulse: frame captured
//   active_requester   index of the requester being served
//   busy               FSM is not in IDLE
//   frame_done         single-cycle pulse: both bytes sent
//   frame_error        single-cycle pulse: watchdog abort
//   tx_has_data        to UART_TX.has_data (one-cycle strobe per byte)
//   tx_data            to UART_TX.data_to_send (held until the next byte)
//   tx_active          from UART_TX.is_transmitting
//   tx_done            from UART_TX.transmission_done
//   debug_state        current FSM state encoding
//
// Handshake: a byte is offered only when tx_active is low; tx_has_data is
// high for exactly one cycle and the byte counts as sent when tx_done is
// sampled high in the following WAIT state.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
  parameter int IDX_W          = $clog2(NUM_REQUESTERS)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQUESTERS-1:0]   request,
  input  logic [8*NUM_REQUESTERS-1:0] request_header,
  input  logic [8*NUM_REQUESTERS-1:0] request_payload,
  output logic [NUM_REQUESTERS-1:0]   grant,
  output logic [IDX_W-1:0]            active_requester,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_error,
  output logic                        tx_has_data,
  output logic [7:0]                  tx_data,
  input  logic                        tx_active,
  input  logic                        tx_done,
  output logic [2:0]                  debug_state
);

  arb_state_e                state_q, state_d;
  logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]          active_q, active_d;
  logic [IDX_W-1:0]          last_q, last_d;
  logic [7:0]                pay_q, pay_d;
  logic [7:0]                txd_q, txd_d;
  logic                      txv_q, txv_d;
  logic                      err_q, err_d;
  logic [IDX_W-1:0]          winner_idx;
  logic                      any_request;
  logic                      timeout;

  round_robin_picker #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .IDX_W          (IDX_W)
  ) u_picker (
    .request     (request),
    .last_served (last_q),
    .winner_idx  (winner_idx),
    .any_request (any_request)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WD_LIMIT = TIMEOUT_MULT * CLOCKS_PER_BIT;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Counter is 0 on the first WAIT cycle, so WD_LIMIT-1 marks the last of
  // WD_LIMIT cycles spent waiting.
  always_comb begin
    wd_d = '0;
    if (state_q == WAIT_HDR || state_q == WAIT_PAY) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign timeout = (wd_q == WD_W'(WD_LIMIT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = '0;
    active_d = active_q;
    last_d   = last_q;
    pay_d    = pay_q;
    txd_d    = txd_q;
    txv_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_request) begin
          grant_d[winner_idx] = 1'b1;
          active_d            = winner_idx;
          txd_d               = request_header[{winner_idx, 3'b000} +: 8];
          pay_d               = request_payload[{winner_idx, 3'b000} +: 8];
          state_d             = LOAD_HDR;
        end
      end
      LOAD_HDR: begin
        if (!tx_active) begin
          txv_d   = 1'b1;
          state_d = WAIT_HDR;
        end
      end
      WAIT_HDR: begin
        if (tx_done) begin
          txd_d   = pay_q;
          state_d = LOAD_PAY;
        end else if (timeout) begin
          err_d   = 1'b1;
          last_d  = active_q;
          state_d = IDLE;
        end
      end
      LOAD_PAY: begin
        if (!tx_active) begin
          txv_d   = 1'b1;
          state_d = WAIT_PAY;
        end
      end
      WAIT_PAY: begin
        if (tx_done) begin
          state_d = COMPLETE;
        end else if (timeout) begin
          err_d   = 1'b1;
          last_d  = active_q;
          state_d = IDLE;
        end
      end
      COMPLETE: begin
        last_d  = active_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      active_q <= '0;
      last_q   <= IDX_W'(NUM_REQUESTERS - 1);
      pay_q    <= '0;
      txd_q    <= '0;
      txv_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      active_q <= active_d;
      last_q   <= last_d;
      pay_q    <= pay_d;
      txd_q    <= txd_d;
      txv_q    <= txv_d;
      err_q    <= err_d;
    end
  end

  assign grant            = grant_q;
  assign active_requester = active_q;
  assign busy             = (state_q != IDLE);
  assign frame_done       = (state_q == COMPLETE);
  assign frame_error      = err_q;
  assign tx_has_data      = txv_q;
  assign tx_data          = txd_q;
  assign debug_state      = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. The UART transmitter is modelled by
// driving tx_active / tx_done directly; bytes offered on tx_has_data are
// checked against an expected queue filled when each grant is observed.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   request;
  logic [8*N-1:0] request_header;
  logic [8*N-1:0] request_payload;
  logic [N-1:0]   grant;
  logic [1:0]     active_requester;
  logic           busy;
  logic           frame_done;
  logic           frame_error;
  logic           tx_has_data;
  logic [7:0]     tx_data;
  logic           tx_active;
  logic           tx_done;
  logic [2:0]     debug_state;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  uart_tx_arbiter dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .request          (request),
    .request_header   (request_header),
    .request_payload  (request_payload),
    .grant            (grant),
    .active_requester (active_requester),
    .busy             (busy),
    .frame_done       (frame_done),
    .frame_error      (frame_error),
    .tx_has_data      (tx_has_data),
    .tx_data          (tx_data),
    .tx_active        (tx_active),
    .tx_done          (tx_done),
    .debug_state      (debug_state)
  );

  // ---------------- clock / reset ----------------
  always #10 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_active"}, 32'(active_requester), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_frame_error"}, 32'(frame_error), 0);
    check({tag, "_has_data"}, 32'(tx_has_data), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_state"}, 32'(debug_state), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_frame(input int idx, input logic [7:0] hdr, input logic [7:0] pay);
    request_header[idx*8 +: 8]  = hdr;
    request_payload[idx*8 +: 8] = pay;
  endtask

  // Called with the arbiter in IDLE and request[idx] already driven so that
  // idx is the expected winner at the next edge. Runs the full frame and
  // returns with the arbiter back in IDLE.
  task automatic serve_frame(input int idx, input logic [7:0] hdr, input logic [7:0] pay,
                             input bit release_req, input int busy_cycles);
    logic [7:0] b;
    tick();
    check("grant_onehot", 32'(grant), 32'd1 << idx);
    check("grant_active", 32'(active_requester), 32'(idx));
    check("grant_busy", 32'(busy), 1);
    check("grant_state", 32'(debug_state), 1);
    check("grant_tx_data", 32'(tx_data), 32'(hdr));
    exp_q.push_back(hdr);
    exp_q.push_back(pay);
    if (release_req) request[idx] = 1'b0;
    // latched frame must not follow later input changes
    set_frame(idx, ~hdr, ~pay);
    for (int k = 0; k < 2; k++) begin
      if (k == 0 && busy_cycles > 0) begin
        tx_active = 1'b1;
        for (int c = 0; c < busy_cycles; c++) begin
          tick();
          check("busy_line_hold", 32'(tx_has_data), 0);
          check("busy_line_state", 32'(debug_state), 1);
        end
      end
      tx_active = 1'b0;
      tick();
      b = exp_q.pop_front();
      check("has_data_pulse", 32'(tx_has_data), 1);
      check("tx_byte", 32'(tx_data), 32'(b));
      check("wait_state", 32'(debug_state), (k == 0) ? 2 : 4);
      check("grant_cleared", 32'(grant), 0);
      tx_active = 1'b1;
      tick();
      check("has_data_single", 32'(tx_has_data), 0);
      check("tx_byte_held", 32'(tx_data), 32'(b));
      tick();
      tx_active = 1'b0;
      tx_done   = 1'b1;
      tick();
      tx_done = 1'b0;
      if (k == 0) begin
        check("load_pay_state", 32'(debug_state), 3);
        check("load_pay_data", 32'(tx_data), 32'(pay));
      end
    end
    check("frame_done_pulse", 32'(frame_done), 1);
    check("complete_state", 32'(debug_state), 5);
    tick();
    check("frame_done_single", 32'(frame_done), 0);
    check("idle_state", 32'(debug_state), 0);
    check("idle_busy", 32'(busy), 0);
    set_frame(idx, hdr, pay);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    reset_n         = 1'b0;
    request         = '0;
    request_header  = '0;
    request_payload = '0;
    tx_active       = 1'b0;
    tx_done         = 1'b0;
    repeat (3) tick();
    check_reset_outputs("por");
    reset_n = 1'b1;
    tick();

    // Single frame from requester 2.
    set_frame(2, 8'hA5, 8'hCD);
    request = 4'b0100;
    serve_frame(2, 8'hA5, 8'hCD, 1'b1, 0);

    // Simultaneous 1 and 3 after reset: 1 first, then 3, then 1 again.
    do_reset();
    set_frame(1, 8'h31, 8'h41);
    set_frame(3, 8'h33, 8'h43);
    request = 4'b1010;
    serve_frame(1, 8'h31, 8'h41, 1'b1, 0);
    serve_frame(3, 8'h33, 8'h43, 1'b1, 0);
    request = 4'b1010;
    serve_frame(1, 8'h31, 8'h41, 1'b1, 0);
    serve_frame(3, 8'h33, 8'h43, 1'b1, 0);

    // Fairness: everyone holds request; last served is 3.
    for (int i = 0; i < N; i++) set_frame(i, 8'(8'h10 + i), 8'(8'h20 + i));
    request = 4'b1111;
    serve_frame(0, 8'h10, 8'h20, 1'b0, 0);
    serve_frame(1, 8'h11, 8'h21, 1'b0, 0);
    serve_frame(2, 8'h12, 8'h22, 1'b0, 0);
    serve_frame(3, 8'h13, 8'h23, 1'b0, 0);
    serve_frame(0, 8'h10, 8'h20, 1'b0, 0);
    request = 4'b0000;

    // Busy line: transmitter still active when the header is ready.
    set_frame(1, 8'h5A, 8'h6B);
    request = 4'b0010;
    serve_frame(1, 8'h5A, 8'h6B, 1'b1, 3);

    // Mid-frame reset during WAIT_PAY (last served is 1).
    set_frame(2, 8'h77, 8'h88);
    request = 4'b0100;
    tick();
    check("mr_grant", 32'(grant), 32'h4);
    request = 4'b0000;
    tick();
    check("mr_hdr_has_data", 32'(tx_has_data), 1);
    tx_active = 1'b1;
    tick();
    tx_active = 1'b0;
    tx_done   = 1'b1;
    tick();
    tx_done = 1'b0;
    check("mr_load_pay", 32'(debug_state), 3);
    tick();
    check("mr_wait_pay", 32'(debug_state), 4);
    check("mr_pay_data", 32'(tx_data), 32'h88);
    tx_active = 1'b1;
    reset_n   = 1'b0;
    tick();
    check_reset_outputs("midreset");
    reset_n   = 1'b1;
    tx_active = 1'b0;
    tx_done   = 1'b1;
    tick();
    tx_done = 1'b0;
    check("mr_late_done_state", 32'(debug_state), 0);
    check("mr_no_frame_done", 32'(frame_done), 0);
    check("mr_no_grant", 32'(grant), 0);
    // 0 and 2 compete: without the reset 2 would win after 1.
    set_frame(0, 8'h01, 8'h02);
    request = 4'b0101;
    serve_frame(0, 8'h01, 8'h02, 1'b1, 0);
    serve_frame(2, 8'h77, 8'h88, 1'b1, 0);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Watchdog: tx_done never arrives for the header byte.
    request = 4'b0010;
    tick();
    check("to_grant", 32'(grant), 32'h2);
    request = 4'b0000;
    tick();
    check("to_wait_hdr", 32'(debug_state), 2);
    cnt = 0;
    while (cnt < 6000 && !frame_error) begin
      tick();
      cnt++;
    end
    check("to_cycles", 32'(cnt), 5220);
    check("to_state_idle", 32'(debug_state), 0);
    check("to_no_frame_done", 32'(frame_done), 0);
    tick();
    check("to_error_single", 32'(frame_error), 0);
    // last served is now 1, so 1 and 2 competing gives 2.
    set_frame(1, 8'h91, 8'h92);
    set_frame(2, 8'hA1, 8'hA2);
    request = 4'b0110;
    serve_frame(2, 8'hA1, 8'hA2, 1'b1, 0);
    serve_frame(1, 8'h91, 8'h92, 1'b1, 0);
`else
    cnt = 0;
    check("frame_error_tied", 32'(frame_error), 32'(cnt));
`endif

    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `UART_TX` instance among several on-chip requesters (sensor reader, status reporter, error logger, and so on). Each requester submits a two-byte frame: a header byte followed by a payload byte. The arbiter grants one requester at a time and drives the `UART_TX` `has_data`/`data_to_send` inputs byte by byte. It advances on `UART_TX`'s `transmission_done`. It sits between the sensor-side logic and the single serial TX line.

## Interface
Parameters:
- `NUM_REQUESTERS`, default 4: number of requester ports, range 2..8.
- `CLOCKS_PER_BIT`, default 435: UART bit period in clocks. Used only for the timeout.
- `IDX_W`, default `$clog2(NUM_REQUESTERS)`: index width.

Ports (one clock; reset is synchronous and active-low):
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `request`  in  NUM_REQUESTERS  per-requester level request. Held high until that requester's `grant`.
- `request_header`  in  8*NUM_REQUESTERS  header byte of requester i, in bits [8i+7:8i].
- `request_payload`  in  8*NUM_REQUESTERS  payload byte of requester i, in bits [8i+7:8i].
- `grant`  out  NUM_REQUESTERS  one-hot, one-cycle pulse: frame captured.
- `active_requester`  out  IDX_W  index of the requester currently being served.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse: both bytes sent.
- `frame_error`  out  1  one-cycle pulse on timeout abort.
- `tx_has_data`  out  1  drives `UART_TX.has_data`.
- `tx_data`  out  8  drives `UART_TX.data_to_send`.
- `tx_active`  in  1  from `UART_TX.is_transmitting`.
- `tx_done`  in  1  from `UART_TX.transmission_done`.
- `debug_state`  out  3  current state encoding.

## Operation
States and encodings: IDLE=0, LOAD_HDR=1, WAIT_HDR=2, LOAD_PAY=3, WAIT_PAY=4, COMPLETE=5.
- **IDLE:** if any `request` bit is high, pick the winner by round-robin. The search starts at `last_served+1` and wraps modulo NUM_REQUESTERS.
  - Latch the winner's header and payload into internal registers.
  - Set `active_requester`, pulse the winner's `grant`, and go to LOAD_HDR.
- **LOAD_HDR:** `tx_data`=header.
  - If `tx_active`=0: assert `tx_has_data` for exactly one cycle, then go to WAIT_HDR.
  - If `tx_active`=1: hold in LOAD_HDR with `tx_has_data`=0.
- **WAIT_HDR:** `tx_has_data`=0 and `tx_data` is held. Go to LOAD_PAY on the cycle `tx_done`=1 is sampled.
- **LOAD_PAY / WAIT_PAY:** identical to LOAD_HDR / WAIT_HDR, with `tx_data`=payload. When `tx_done` is sampled, go to COMPLETE.
- **COMPLETE:** pulse `frame_done`, set `last_served`=`active_requester`, return to IDLE.
- Request inputs are ignored outside IDLE. The latched frame is immune to later input changes.
- A requester that keeps `request` high after `grant` is treated as a new request and re-arbitrated normally.
- Reset values: `grant`=0, `active_requester`=0, `busy`=0, `frame_done`=0, `frame_error`=0, `tx_has_data`=0, `tx_data`=0, `debug_state`=0 (IDLE).
  - `last_served`=NUM_REQUESTERS-1, so requester 0 has first priority after reset.
- Reset mid-frame aborts immediately: no `frame_done` pulse, no `grant`.
  - A byte already started in `UART_TX` completes on the line. Its `tx_done` arrives while the arbiter is in IDLE and is ignored.

## Timing
- `request` is sampled in IDLE on cycle N. `grant` and `busy` are high from cycle N+1, and the state is then LOAD_HDR.
- `tx_has_data` pulses on cycle N+2 at the earliest (when `tx_active`=0).
- `tx_done` sampled on cycle M in WAIT_HDR gives LOAD_PAY at M+1, with the payload `tx_has_data` at M+2 at the earliest.
- `tx_done` in WAIT_PAY on cycle P gives `frame_done` at P+1 and IDLE at P+2. The earliest next `grant` is at P+3.
- Back-to-back frames have 3 idle arbitration cycles between the final `tx_done` and the next `grant`.

## Configuration
- Macro `UART_TX_ARB_TIMEOUT_EN`.
- **When defined:** a watchdog counter of width `$clog2(12*CLOCKS_PER_BIT+1)` clears on entry to each WAIT state and increments every cycle spent there.
  - On reaching 12*CLOCKS_PER_BIT without `tx_done`, the arbiter pulses `frame_error` for one cycle and returns to IDLE.
  - `last_served` is updated on this abort and `frame_done` is not pulsed.
- **When undefined:** no counter exists, WAIT states wait indefinitely, and `frame_error` is tied to 0.

## Structure
- Package `uart_arb_pkg` holds:
  - the state localparams (IDLE..COMPLETE, 3-bit);
  - the default CLOCKS_PER_BIT (435, i.e. 50 MHz / 115200 + 1);
  - the timeout multiplier constant 12.
- Sub-module `round_robin_picker` is combinational. Inputs are `request` and `last_served`; outputs are `winner_idx` and `any_request`.
- The FSM, frame registers and watchdog live in `uart_tx_arbiter`.

## Test plan
Bench: arbiter driving real `UART_TX`, with `UART_TX` looped back into `UART_RX`; 50 MHz clock, CLOCKS_PER_BIT=435.
- **Single frame:** requester 2 requests with header 0xA5, payload 0xCD. Expect `grant`[2] one cycle later, `UART_RX` receiving 0xA5 then 0xCD, and one `frame_done` pulse.
- **Round-robin fairness:** all four requesters hold `request` high, with header=0x10+i. Expect grants in order 0,1,2,3,0, with RX headers 0x10, 0x11, 0x12, 0x13, 0x10.
- **Simultaneous requests:** requesters 1 and 3 request together after reset. Expect 1 served before 3. Re-request both after both frames; expect 1 again (`last_served`=3).
- **Busy line:** force `tx_active`=1 in LOAD_HDR. Expect `tx_has_data` held 0; it pulses exactly one cycle after `tx_active` falls.
- **Mid-frame reset:** assert `reset_n`=0 during WAIT_PAY. Expect all outputs at reset values the next cycle, no `frame_done`, and requester 0 winning the next arbitration.
- **Timeout** (`UART_TX_ARB_TIMEOUT_EN` defined): `tx_done` stuck at 0. Expect a `frame_error` pulse after 12×435 = 5220 cycles in WAIT_HDR, then IDLE.
